// File: rtl/fp16_mul_prim_stage_if.sv
// Operand/result bundle for the FP16 multiplier primitive datapath slice.
// The master drives the operands and controls; the slave (the stage) returns
// the registered results.
interface fp16_mul_prim_stage_if;
   logic       in_valid;
   logic [4:0] add_a;
   logic [4:0] add_b;
   logic [4:0] mux5_in0;
   logic [4:0] mux5_in1;
   logic       mux5_sel;
   logic [9:0] mux10_in0;
   logic [9:0] mux10_in1;
   logic       mux10_sel;
   logic       sticky_clr;
   logic       out_valid;
   logic [4:0] add_sum;
   logic       add_carry;
   logic [4:0] mux5_out;
   logic [9:0] mux10_out;
   logic       sticky_carry;

   modport master (
      output in_valid, add_a, add_b, mux5_in0, mux5_in1, mux5_sel,
             mux10_in0, mux10_in1, mux10_sel, sticky_clr,
      input  out_valid, add_sum, add_carry, mux5_out, mux10_out, sticky_carry
   );

   modport slave (
      input  in_valid, add_a, add_b, mux5_in0, mux5_in1, mux5_sel,
             mux10_in0, mux10_in1, mux10_sel, sticky_clr,
      output out_valid, add_sum, add_carry, mux5_out, mux10_out, sticky_carry
   );
endinterface

// File: rtl/fp16_mul_prim_stage.sv
// FP16 multiplier primitive slice: 5-bit exponent adder, 5-bit exponent
// selector and 10-bit mantissa selector behind one valid-qualified register.
// Optional feature macro: FP16_MUL_PRIM_STICKY_CARRY_EN enables a sticky
// record of adder carry-outs; when undefined sticky_carry reads 0.
module fp16_mul_prim_stage (
   input  logic                  clk,
   input  logic                  rst_n,
   fp16_mul_prim_stage_if.slave  bus
);

   logic [5:0] add_full;
   logic       out_valid_q, out_valid_d;
   logic [4:0] add_sum_q,   add_sum_d;
   logic       add_carry_q, add_carry_d;
   logic [4:0] mux5_out_q,  mux5_out_d;
   logic [9:0] mux10_out_q, mux10_out_d;
   logic       sticky_q,    sticky_d;

   // Combinational datapath plus capture/hold selection of the next state.
   always_comb begin
      add_full    = {1'b0, bus.add_a} + {1'b0, bus.add_b};
      out_valid_d = bus.in_valid;
      add_sum_d   = add_sum_q;
      add_carry_d = add_carry_q;
      mux5_out_d  = mux5_out_q;
      mux10_out_d = mux10_out_q;
      if (bus.in_valid) begin
         add_sum_d   = add_full[4:0];
         add_carry_d = add_full[5];
         mux5_out_d  = bus.mux5_sel  ? bus.mux5_in1  : bus.mux5_in0;
         mux10_out_d = bus.mux10_sel ? bus.mux10_in1 : bus.mux10_in0;
      end
   end

`ifdef FP16_MUL_PRIM_STICKY_CARRY_EN
   // Sticky carry: a captured carry sets it, clear drops it, set has priority.
   always_comb begin
      sticky_d = sticky_q;
      if (bus.sticky_clr)
         sticky_d = 1'b0;
      if (bus.in_valid && add_full[5])
         sticky_d = 1'b1;
   end
`else
   logic unused_sticky_clr;
   assign unused_sticky_clr = bus.sticky_clr;

   // Feature disabled: the sticky flag never leaves zero.
   always_comb begin
      sticky_d = 1'b0;
   end
`endif

   // Result register with asynchronous clear of every output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         add_sum_q   <= 5'd0;
         add_carry_q <= 1'b0;
         mux5_out_q  <= 5'd0;
         mux10_out_q <= 10'd0;
         sticky_q    <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         add_sum_q   <= add_sum_d;
         add_carry_q <= add_carry_d;
         mux5_out_q  <= mux5_out_d;
         mux10_out_q <= mux10_out_d;
         sticky_q    <= sticky_d;
      end
   end

   assign bus.out_valid    = out_valid_q;
   assign bus.add_sum      = add_sum_q;
   assign bus.add_carry    = add_carry_q;
   assign bus.mux5_out     = mux5_out_q;
   assign bus.mux10_out    = mux10_out_q;
   assign bus.sticky_carry = sticky_q;

endmodule

// File: tb/tb_fp16_mul_prim_stage.sv
// Directed testbench for fp16_mul_prim_stage; expected values hand-computed.
module tb_fp16_mul_prim_stage;

`ifdef FP16_MUL_PRIM_STICKY_CARRY_EN
   localparam bit STICKY_EN = 1'b1;
`else
   localparam bit STICKY_EN = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   fp16_mul_prim_stage_if bus ();

   fp16_mul_prim_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus.in_valid   = 1'b0;
      bus.add_a      = 5'd0;
      bus.add_b      = 5'd0;
      bus.mux5_in0   = 5'd0;
      bus.mux5_in1   = 5'd0;
      bus.mux5_sel   = 1'b0;
      bus.mux10_in0  = 10'd0;
      bus.mux10_in1  = 10'd0;
      bus.mux10_sel  = 1'b0;
      bus.sticky_clr = 1'b0;
   endtask

   task automatic test_reset();
      logic [22:0] got;
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.add_a     = 5'd31;
      bus.add_b     = 5'd31;
      bus.mux5_in1  = 5'd21;
      bus.mux5_sel  = 1'b1;
      bus.mux10_in0 = 10'h155;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      got = {bus.out_valid, bus.add_carry, bus.add_sum, bus.mux5_out, bus.mux10_out, bus.sticky_carry};
      n_vec++;
      $display("reset_pre: got %h", got);
      if (got !== {1'b1, 1'b1, 5'd30, 5'd21, 10'h155, STICKY_EN}) begin
         n_err++;
         $display("FAIL reset_pre: got %h want %h", got, {1'b1, 1'b1, 5'd30, 5'd21, 10'h155, STICKY_EN});
      end
      #1 rst_n = 1'b0;
      #1;
      got = {bus.out_valid, bus.add_carry, bus.add_sum, bus.mux5_out, bus.mux10_out, bus.sticky_carry};
      n_vec++;
      $display("reset_async: got %h", got);
      if (got !== 23'd0) begin
         n_err++;
         $display("FAIL reset_async: got %h want 0", got);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      got = {bus.out_valid, bus.add_carry, bus.add_sum, bus.mux5_out, bus.mux10_out, bus.sticky_carry};
      n_vec++;
      $display("reset_release: got %h", got);
      if (got !== 23'd0) begin
         n_err++;
         $display("FAIL reset_release: got %h want 0", got);
      end
   endtask

   task automatic test_adder();
      logic [4:0] va [4] = '{5'd15, 5'd31, 5'd19, 5'd31};
      logic [4:0] vb [4] = '{5'd15, 5'd1,  5'd17, 5'd31};
      logic [6:0] ex [4] = '{{1'b1, 1'b0, 5'd30}, {1'b1, 1'b1, 5'd0},
                             {1'b1, 1'b1, 5'd4},  {1'b1, 1'b1, 5'd30}};
      logic [6:0] got;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.add_a    = va[i];
         bus.add_b    = vb[i];
         @(negedge clk);
         bus.in_valid = 1'b0;
         got = {bus.out_valid, bus.add_carry, bus.add_sum};
         n_vec++;
         $display("adder %0d+%0d: valid=%b carry=%b sum=%0d", va[i], vb[i], got[6], got[5], got[4:0]);
         if (got !== ex[i]) begin
            n_err++;
            $display("FAIL adder_%0d: got %b want %b", i, got, ex[i]);
         end
      end
   endtask

   task automatic test_select();
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.mux5_in0  = 5'd17;
      bus.mux5_in1  = 5'd0;
      bus.mux5_sel  = 1'b1;
      bus.mux10_in0 = 10'h2AA;
      bus.mux10_in1 = 10'h3FF;
      bus.mux10_sel = 1'b1;
      @(negedge clk);
      n_vec++;
      $display("select sel=1: mux5=%0d mux10=%h", bus.mux5_out, bus.mux10_out);
      if ({bus.mux5_out, bus.mux10_out} !== {5'd0, 10'h3FF}) begin
         n_err++;
         $display("FAIL select_sel1: got %0d/%h want 0/3ff", bus.mux5_out, bus.mux10_out);
      end
      bus.mux5_sel  = 1'b0;
      bus.mux10_sel = 1'b0;
      @(negedge clk);
      n_vec++;
      $display("select sel=0: mux5=%0d mux10=%h", bus.mux5_out, bus.mux10_out);
      if ({bus.mux5_out, bus.mux10_out} !== {5'd17, 10'h2AA}) begin
         n_err++;
         $display("FAIL select_sel0: got %0d/%h want 17/2aa", bus.mux5_out, bus.mux10_out);
      end
      bus.mux5_in0  = 'x;
      bus.mux5_in1  = 5'd9;
      bus.mux5_sel  = 1'b1;
      bus.mux10_in0 = 10'h155;
      bus.mux10_in1 = 'x;
      bus.mux10_sel = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      n_vec++;
      $display("select x_unchosen: mux5=%0d mux10=%h", bus.mux5_out, bus.mux10_out);
      if ($isunknown({bus.mux5_out, bus.mux10_out}) || {bus.mux5_out, bus.mux10_out} !== {5'd9, 10'h155}) begin
         n_err++;
         $display("FAIL select_x: got %0d/%h want 9/155", bus.mux5_out, bus.mux10_out);
      end
      idle_inputs();
   endtask

   task automatic test_hold();
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.add_a    = 5'd3;
      bus.add_b    = 5'd4;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.add_a    = 5'd10;
      bus.add_b    = 5'd11;
      n_vec++;
      $display("hold capture: valid=%b sum=%0d", bus.out_valid, bus.add_sum);
      if ({bus.out_valid, bus.add_sum} !== {1'b1, 5'd7}) begin
         n_err++;
         $display("FAIL hold_capture: got %b/%0d want 1/7", bus.out_valid, bus.add_sum);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_vec++;
         $display("hold cycle %0d: valid=%b sum=%0d", i, bus.out_valid, bus.add_sum);
         if ({bus.out_valid, bus.add_sum} !== {1'b0, 5'd7}) begin
            n_err++;
            $display("FAIL hold_%0d: got %b/%0d want 0/7", i, bus.out_valid, bus.add_sum);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] va [4] = '{5'd1, 5'd16, 5'd30, 5'd8};
      logic [4:0] vb [4] = '{5'd2, 5'd16, 5'd5,  5'd0};
      logic [4:0] vm [4] = '{5'd11, 5'd12, 5'd13, 5'd14};
      logic [6:0] ex [4] = '{{1'b1, 1'b0, 5'd3}, {1'b1, 1'b1, 5'd0},
                             {1'b1, 1'b1, 5'd3}, {1'b1, 1'b0, 5'd8}};
      logic [11:0] got;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.add_a    = va[i];
         bus.add_b    = vb[i];
         bus.mux5_in0 = vm[i];
         bus.mux5_sel = 1'b0;
         @(posedge clk);
         #1;
         got = {bus.out_valid, bus.add_carry, bus.add_sum, bus.mux5_out};
         n_vec++;
         $display("b2b %0d: valid=%b carry=%b sum=%0d mux5=%0d", i, got[11], got[10], got[9:5], got[4:0]);
         if (got !== {ex[i], vm[i]}) begin
            n_err++;
            $display("FAIL b2b_%0d: got %h want %h", i, got, {ex[i], vm[i]});
         end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_sticky();
      // steps: clr alone, cap(31,1), cap(1,1), idle, clr+cap(31,1), clr alone
      logic       s_cap [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [4:0] s_a   [6] = '{5'd0, 5'd31, 5'd1, 5'd0, 5'd31, 5'd0};
      logic [4:0] s_b   [6] = '{5'd0, 5'd1,  5'd1, 5'd0, 5'd1,  5'd0};
      logic       s_clr [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic       s_exp [6] = '{1'b0, STICKY_EN, STICKY_EN, STICKY_EN, STICKY_EN, 1'b0};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.in_valid   = s_cap[i];
         bus.add_a      = s_a[i];
         bus.add_b      = s_b[i];
         bus.sticky_clr = s_clr[i];
         @(negedge clk);
         idle_inputs();
         n_vec++;
         $display("sticky step %0d: cap=%b clr=%b sticky=%b", i, s_cap[i], s_clr[i], bus.sticky_carry);
         if (bus.sticky_carry !== s_exp[i]) begin
            n_err++;
            $display("FAIL sticky_%0d: got %b want %b", i, bus.sticky_carry, s_exp[i]);
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_adder();
      test_select();
      test_hold();
      test_back_to_back();
      test_sticky();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fp16_mul_prim_stage.md
# fp16_mul_prim_stage

Registered primitive datapath slice for the half-precision (FP16) multiplier. It bundles three elements behind one input-valid/output-valid register stage: the 5-bit exponent adder (sum plus carry-out), the 5-bit exponent selector, and the 10-bit mantissa selector. The multiplier control logic drives it to add biased exponents and to force zero/infinity patterns onto the result fields.

## Interface
Parameters:
- None. All widths are fixed at 5 (exponent) and 10 (mantissa).

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  capture all operand inputs this cycle
- add_a  input  5  adder operand A (unsigned)
- add_b  input  5  adder operand B (unsigned)
- mux5_in0  input  5  exponent selector input, chosen when mux5_sel=0
- mux5_in1  input  5  exponent selector input, chosen when mux5_sel=1
- mux5_sel  input  1  exponent selector control
- mux10_in0  input  10  mantissa selector input, chosen when mux10_sel=0
- mux10_in1  input  10  mantissa selector input, chosen when mux10_sel=1
- mux10_sel  input  1  mantissa selector control
- sticky_clr  input  1  clear the sticky carry flag
- out_valid  output  1  registered outputs were updated by the previous capture
- add_sum  output  5  registered (add_a + add_b) mod 32
- add_carry  output  1  registered bit 5 of add_a + add_b
- mux5_out  output  5  registered exponent selector result
- mux10_out  output  10  registered mantissa selector result
- sticky_carry  output  1  sticky OR of captured add_carry values (see Configuration)

## Operation
- Adder: 6-bit result {add_carry, add_sum} = add_a + add_b, zero-extended unsigned. No carry-in. Max 31+31 = 62 gives carry=1, sum=30.
- Exponent selector: mux5_out = mux5_sel ? mux5_in1 : mux5_in0.
- Mantissa selector: mux10_out = mux10_sel ? mux10_in1 : mux10_in0.
- The three functions are independent. All are computed combinationally from the current inputs and captured together.
- Capture: on a rising clk with in_valid=1, add_sum, add_carry, mux5_out and mux10_out load their new values and out_valid is set to 1.
- Hold: on a rising clk with in_valid=0, the data outputs keep their values and out_valid goes to 0.
- X on a selector input whose side is not chosen does not propagate to the output.

## Timing
- Latency is 1 cycle from an in_valid=1 edge to valid outputs. Throughput is one capture per cycle, back-to-back.
- There is no backpressure. The downstream consumer samples the outputs when out_valid=1.
- While rst_n=0, all outputs are forced to 0 immediately, without waiting for clk: out_valid, add_sum, add_carry, mux5_out, mux10_out and sticky_carry.
- On the first rising edge after rst_n deasserts, normal capture or hold applies.
- Reset mid-stream discards any in-flight capture. Outputs read 0 and out_valid reads 0 until the next in_valid=1 edge.
- sticky_carry updates on the same edge as add_carry.

## Configuration
- Macro: FP16_MUL_PRIM_STICKY_CARRY_EN.
- Defined:
  - sticky_carry is set on any capture edge whose computed carry is 1.
  - It is cleared on an edge with sticky_clr=1.
  - If set and clear occur on the same edge, set wins.
  - Otherwise it holds.
  - Its reset value is 0.
- Undefined: sticky_carry is tied to 0, sticky_clr is ignored, and the port list is unchanged.

## Test plan
- Reset: assert rst_n=0 mid-cycle with the outputs nonzero -> all outputs go to 0 without waiting for a clock edge; out_valid=0 after release until the first capture.
- Adder: (15,15) -> sum=30, carry=0; (31,1) -> sum=0, carry=1; (19,17) -> sum=4, carry=1; (31,31) -> sum=30, carry=1. Each result appears one cycle after capture with out_valid=1.
- Selectors: mux5 in0=17, in1=0, sel=1 -> 0; mux10 in0=0x2AA, in1=0x3FF, sel=1 -> 0x3FF; sel=0 -> 0x2AA. Apply X on the unchosen input -> output is not X.
- Hold: capture (3,4) and then hold in_valid=0 for 5 cycles -> sum stays 7 and out_valid=0 on every hold cycle.
- Back-to-back: capture 4 consecutive operand sets -> 4 consecutive out_valid=1 cycles, each showing the matching results in order.
- Sticky (macro on): capture (31,1), then (1,1) -> sticky_carry=1 and held. sticky_clr=1 together with a (31,1) capture -> stays 1. sticky_clr=1 alone -> 0. With the macro off, sticky_carry is always 0.
